// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline: latch enables, flushes, halt and stall accounting.
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             jump,
  input  logic             brtaken,
  input  logic             halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             flush_EXMEM,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DDONE = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   adv;
  logic   load_use;

  // Pipeline may advance when fetch is back and any data access is done or already captured.
  always_comb begin
    adv      = ihit & (~mem_req | dhit | (state == DDONE));
    load_use = idex_memread & (idex_rt != 5'd0) &
               ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
  end

  // State register; reset drops any captured dhit.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: halt commits on an advancing cycle; DDONE remembers a dhit that beat ihit.
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (halt && adv) begin
          next_state = HALT;
        end else if (mem_req && dhit && !ihit) begin
          next_state = DDONE;
        end
      end
      DDONE: begin
        if (halt && adv) begin
          next_state = HALT;
        end else if (ihit) begin
          next_state = RUN;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = RUN;
    endcase
  end

  // Enables and flushes: freeze, advance, then branch flush > load-use bubble > jump squash.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    flush_IFID  = 1'b0;
    flush_IDEX  = 1'b0;
    flush_EXMEM = 1'b0;
    if (nRST && (state != HALT) && adv) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (brtaken) begin
        flush_IFID  = 1'b1;
        flush_IDEX  = 1'b1;
        flush_EXMEM = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        flush_IDEX = 1'b1;
      end else if (jump) begin
        flush_IFID = 1'b1;
      end
    end
  end

  // Sticky halt flag, set on the edge that enters HALT.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      halted <= 1'b0;
    end else if ((state != HALT) && (next_state == HALT)) begin
      halted <= 1'b1;
    end
  end

  // Saturating count of cycles where the PC did not advance, frozen once halted.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if ((state != HALT) && !pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one full-width instance plus a 2-bit counter instance.
module tb_pipeline_ctrl;

  logic       CLK;
  logic       nRST;
  logic       ihit, dhit, mem_req, idex_memread, jump, brtaken, halt;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        flush_IFID, flush_IDEX, flush_EXMEM, halted;
  logic [31:0] stall_cnt;

  logic        pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2;
  logic        flush_IFID2, flush_IDEX2, flush_EXMEM2, halted2;
  logic [1:0]  stall_cnt2;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] OUT_ZERO = 8'b00000_000;
  localparam logic [7:0] OUT_NORM = 8'b11111_000;
  localparam logic [7:0] OUT_LU   = 8'b00111_010;
  localparam logic [7:0] OUT_BR   = 8'b11111_111;
  localparam logic [7:0] OUT_JMP  = 8'b11111_100;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .jump(jump), .brtaken(brtaken), .halt(halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .flush_EXMEM(flush_EXMEM),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.CNT_W(2)) dut2 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .jump(jump), .brtaken(brtaken), .halt(halt),
    .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_en(idex_en2), .exmem_en(exmem_en2), .memwb_en(memwb_en2),
    .flush_IFID(flush_IFID2), .flush_IDEX(flush_IDEX2), .flush_EXMEM(flush_EXMEM2),
    .halted(halted2), .stall_cnt(stall_cnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] outs();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, flush_IFID, flush_IDEX, flush_EXMEM};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ih, input logic dh, input logic mr, input logic lm,
                       input logic [4:0] rt_ex, input logic [4:0] rs_id, input logic [4:0] rt_id,
                       input logic jp, input logic br, input logic hl);
    ihit = ih; dhit = dh; mem_req = mr; idex_memread = lm;
    idex_rt = rt_ex; ifid_rs = rs_id; ifid_rt = rt_id;
    jump = jp; brtaken = br; halt = hl;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    nRST = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("reset_outs_forced", 32'(outs()), 32'(OUT_ZERO));
    tick();
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_cnt", stall_cnt, 32'd0);
    chk("reset_cnt2", 32'(stall_cnt2), 32'd0);

    nRST = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("normal_outs", 32'(outs()), 32'(OUT_NORM));
    tick();
    chk("normal_cnt", stall_cnt, 32'd0);

    // Load-use on rs
    drive(1, 0, 0, 1, 5'd5, 5'd5, 5'd2, 0, 0, 0);
    chk("lu_rs_outs", 32'(outs()), 32'(OUT_LU));
    tick();
    chk("lu_rs_cnt", stall_cnt, 32'd1);
    drive(1, 0, 0, 0, 5'd0, 5'd5, 5'd2, 0, 0, 0);
    chk("after_lu_outs", 32'(outs()), 32'(OUT_NORM));
    tick();
    chk("after_lu_cnt", stall_cnt, 32'd1);

    // r0 destination never hazards
    drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("lu_r0_outs", 32'(outs()), 32'(OUT_NORM));
    tick();
    chk("lu_r0_cnt", stall_cnt, 32'd1);

    // Load-use on rt
    drive(1, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0);
    chk("lu_rt_outs", 32'(outs()), 32'(OUT_LU));
    tick();
    chk("lu_rt_cnt", stall_cnt, 32'd2);

    // Branch beats load-use and jump
    drive(1, 0, 0, 1, 5'd7, 5'd7, 5'd7, 1, 1, 0);
    chk("br_lu_jmp_outs", 32'(outs()), 32'(OUT_BR));
    tick();
    chk("br_lu_jmp_cnt", stall_cnt, 32'd2);

    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    chk("jump_outs", 32'(outs()), 32'(OUT_JMP));
    tick();

    // dhit before ihit -> DDONE, then ihit alone advances
    drive(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("ddone_t0_outs", 32'(outs()), 32'(OUT_ZERO));
    tick();
    chk("ddone_t0_cnt", stall_cnt, 32'd3);
    drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("ddone_t1_outs", 32'(outs()), 32'(OUT_ZERO));
    tick();
    drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("ddone_t2_outs", 32'(outs()), 32'(OUT_NORM));
    tick();
    chk("ddone_t2_cnt", stall_cnt, 32'd4);

    // Back in RUN: a new access waits for a fresh dhit
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      chk("dwait_outs", 32'(outs()), 32'(OUT_ZERO));
      tick();
    end
    chk("dwait_cnt", stall_cnt, 32'd7);
    drive(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("dhit_adv_outs", 32'(outs()), 32'(OUT_NORM));
    tick();
    chk("dhit_adv_cnt", stall_cnt, 32'd7);
    chk("cnt2_saturated", 32'(stall_cnt2), 32'd3);

    // Reset while in DDONE discards the captured dhit
    drive(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    tick();
    nRST = 1'b0;
    drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("rst_ddone_outs", 32'(outs()), 32'(OUT_ZERO));
    tick();
    chk("rst_ddone_cnt", stall_cnt, 32'd0);
    nRST = 1'b1;
    drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("fresh_dhit_needed", 32'(outs()), 32'(OUT_ZERO));
    tick();
    chk("fresh_dhit_cnt", stall_cnt, 32'd1);
    drive(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("fresh_dhit_adv", 32'(outs()), 32'(OUT_NORM));
    tick();

    // Halt without advance does not halt
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    tick();
    chk("halt_noadv", 32'(halted), 32'd0);
    chk("halt_noadv_cnt", stall_cnt, 32'd2);

    // Halt with advance: one advancing cycle, then frozen
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    chk("halt_cycle_outs", 32'(outs()), 32'(OUT_NORM));
    chk("halt_cycle_flag", 32'(halted), 32'd0);
    tick();
    chk("halted_flag", 32'(halted), 32'd1);
    held = stall_cnt;
    chk("halted_cnt_val", held, 32'd2);
    drive(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 1, 0);
    chk("halted_outs", 32'(outs()), 32'(OUT_ZERO));
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    tick();
    tick();
    chk("halted_cnt_frozen", stall_cnt, 32'd2);
    chk("halted_sticky", 32'(halted), 32'd1);
    chk("halted_outs_idle", 32'(outs()), 32'(OUT_ZERO));

    nRST = 1'b0;
    tick();
    chk("unhalt_flag", 32'(halted), 32'd0);
    chk("unhalt_cnt", stall_cnt, 32'd0);

    // Saturation of the 2-bit counter
    nRST = 1'b1;
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_cnt2", 32'(stall_cnt2), 32'd3);
    chk("sat_cnt32", stall_cnt, 32'd6);
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("sat_resume_outs2", 32'({pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2,
                                 flush_IFID2, flush_IDEX2, flush_EXMEM2}), 32'(OUT_NORM));
    tick();
    chk("sat_hold_cnt2", 32'(stall_cnt2), 32'd3);
    chk("sat_halted2", 32'(halted2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
